// File: rtl/schmidl_cox_metric_divider_pkg.sv
// Shared types and the single restoring-division step used by the
// Schmidl-Cox timing-metric divider.
//   div_state_t : divider FSM encoding (IDLE -> CALC -> DONE -> IDLE)
//   div_step    : one restoring step on a DIV_MAX_W-bit remainder, returns
//                 {quotient bit, next remainder}
package schmidl_cox_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  // Widest divisor the step function can handle; callers zero-extend.
  localparam int unsigned DIV_MAX_W = 64;

  typedef struct packed {
    logic                 q_bit;
    logic [DIV_MAX_W-1:0] r_next;
  } div_step_t;

  // T = {R, bit}; since R < D, T < 2D and one extra bit is enough.
  function automatic div_step_t div_step(input logic [DIV_MAX_W-1:0] r,
                                         input logic                 b,
                                         input logic [DIV_MAX_W-1:0] d);
    logic [DIV_MAX_W:0] t;
    div_step_t          res;
    t = {r, b};
    if (t >= {1'b0, d}) begin
      res.q_bit = 1'b1;
      t         = t - {1'b0, d};
    end else begin
      res.q_bit = 1'b0;
    end
    res.r_next = t[DIV_MAX_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/schmidl_cox_metric_divider_if.sv
// AXI-Stream bundle for the metric divider: dividend (num_*), divisor
// (den_*) and quotient (o_*) channels.
//   master : drives num/den, consumes o (upstream + downstream side)
//   slave  : the divider itself
interface schmidl_cox_metric_divider_if #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned QUOT_WIDTH = 16
);
  logic [WIDTH-1:0]      num_tdata;
  logic                  num_tlast;
  logic                  num_tvalid;
  logic                  num_tready;
  logic [WIDTH-1:0]      den_tdata;
  logic                  den_tlast;
  logic                  den_tvalid;
  logic                  den_tready;
  logic [QUOT_WIDTH-1:0] o_tdata;
  logic                  o_tlast;
  logic                  o_tvalid;
  logic                  o_tready;

  modport master (
    output num_tdata, num_tlast, num_tvalid, input num_tready,
    output den_tdata, den_tlast, den_tvalid, input den_tready,
    input  o_tdata, o_tlast, o_tvalid, output o_tready
  );

  modport slave (
    input  num_tdata, num_tlast, num_tvalid, output num_tready,
    input  den_tdata, den_tlast, den_tvalid, output den_tready,
    output o_tdata, o_tlast, o_tvalid, input o_tready
  );
endinterface

// File: rtl/schmidl_cox_metric_divider.sv
// Iterative restoring divider producing the Schmidl-Cox timing metric
// M = |P|^2 / R^2 as q = floor(N * 2^FRAC_BITS / D), saturated to all ones
// when the quotient does not fit in QUOT_WIDTH bits or D == 0.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-high reset
//   clear  : synchronous clear, same effect as reset
//   axis   : slave modport; num_* dividend, den_* divisor (den_tlast is
//            forwarded to o_tlast), o_* quotient output
// One quotient bit per cycle; o_tvalid rises QUOT_WIDTH+1 cycles after the
// accept cycle, one pair per QUOT_WIDTH+2 cycles at best.
module schmidl_cox_metric_divider
  import schmidl_cox_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FRAC_BITS  = 15,
  parameter int unsigned QUOT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  schmidl_cox_metric_divider_if.slave  axis
);

  localparam int unsigned EW    = WIDTH + FRAC_BITS;
  localparam int unsigned CNT_W = $clog2(QUOT_WIDTH + 1);
  localparam int unsigned IDX_W = (QUOT_WIDTH > 1) ? $clog2(QUOT_WIDTH) : 1;

  if (QUOT_WIDTH < 1 || QUOT_WIDTH > EW) begin : g_bad_quot_width
    $error("schmidl_cox_metric_divider: QUOT_WIDTH must lie in 1..WIDTH+FRAC_BITS");
  end
  if (WIDTH >= DIV_MAX_W) begin : g_bad_width
    $error("schmidl_cox_metric_divider: WIDTH must be below DIV_MAX_W");
  end

  div_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [QUOT_WIDTH-1:0] e_lo;      // only the bits still to be shifted in
  logic [WIDTH-1:0]      d_q;
  logic [WIDTH-1:0]      r_q;
  logic [QUOT_WIDTH-1:0] q_sr;
  logic                  ovf_q;
  logic                  last_q;
  logic [QUOT_WIDTH-1:0] out_data_q;
  logic                  out_last_q;
  logic                  out_valid_q;

  logic                  accept;
  logic [EW-1:0]         e_full;
  logic [EW-1:0]         e_hi;
  logic                  ovf_in;
  logic [IDX_W-1:0]      cnt_idx;
  div_step_t             step;
  logic [QUOT_WIDTH-1:0] q_final;
  logic                  unused_bits;

  // Both channels are taken together or not at all.
  assign accept = (state == IDLE) & axis.num_tvalid & axis.den_tvalid & ~reset & ~clear;
  assign axis.num_tready = accept;
  assign axis.den_tready = accept;

  assign e_full = EW'(axis.num_tdata) << FRAC_BITS;
  assign e_hi   = e_full >> QUOT_WIDTH;
  // The leading remainder already reaching D means the quotient needs more
  // than QUOT_WIDTH bits.
  assign ovf_in = (axis.den_tdata == '0) | (e_hi >= EW'(axis.den_tdata));

  assign cnt_idx = cnt[IDX_W-1:0];

  always_comb begin
    step             = div_step(DIV_MAX_W'(r_q), e_lo[cnt_idx], DIV_MAX_W'(d_q));
    q_final          = q_sr;
    q_final[cnt_idx] = step.q_bit;
  end

  // Remainder stays below D, so the step's upper bits are always zero.
  assign unused_bits = ^{1'b0, axis.num_tlast, step.r_next[DIV_MAX_W-1:WIDTH]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      e_lo        <= '0;
      d_q         <= '0;
      r_q         <= '0;
      q_sr        <= '0;
      ovf_q       <= 1'b0;
      last_q      <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state       <= IDLE;
      cnt         <= '0;
      e_lo        <= '0;
      d_q         <= '0;
      r_q         <= '0;
      q_sr        <= '0;
      ovf_q       <= 1'b0;
      last_q      <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            e_lo   <= e_full[QUOT_WIDTH-1:0];
            d_q    <= axis.den_tdata;
            r_q    <= e_hi[WIDTH-1:0];
            ovf_q  <= ovf_in;
            last_q <= axis.den_tlast;
            cnt    <= CNT_W'(QUOT_WIDTH - 1);
            q_sr   <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          r_q  <= step.r_next[WIDTH-1:0];
          q_sr <= q_final;
          if (cnt == '0) begin
            out_data_q  <= ovf_q ? '1 : q_final;
            out_last_q  <= last_q;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (axis.o_tready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign axis.o_tdata  = out_data_q;
  assign axis.o_tlast  = out_last_q;
  assign axis.o_tvalid = out_valid_q;

endmodule

// File: tb/tb_schmidl_cox_metric_divider.sv
module tb_schmidl_cox_metric_divider;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  schmidl_cox_metric_divider_if #(.WIDTH(32), .QUOT_WIDTH(16)) axis ();

  schmidl_cox_metric_divider #(
    .WIDTH(32), .FRAC_BITS(15), .QUOT_WIDTH(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .axis (axis)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_q(input logic [31:0] n, input logic [31:0] d);
    logic [63:0] q;
    if (d == 32'd0) return 16'hFFFF;
    q = {17'd0, n, 15'd0} / {32'd0, d};
    return (q > 64'hFFFF) ? 16'hFFFF : q[15:0];
  endfunction

  // Present a pair at a negedge, wait (bounded) for acceptance, return one
  // negedge after the accept edge with the valids dropped.
  task automatic send_pair(input logic [31:0] n, input logic [31:0] d, input logic last);
    int w;
    axis.num_tdata  = n;
    axis.den_tdata  = d;
    axis.den_tlast  = last;
    axis.num_tlast  = ~last;
    axis.num_tvalid = 1'b1;
    axis.den_tvalid = 1'b1;
    #1;
    w = 0;
    while (!(axis.num_tready && axis.den_tready) && w < 50) begin
      @(negedge clk); #1; w++;
    end
    chk("accept_ready", 64'({axis.num_tready, axis.den_tready}), 64'd3);
    @(posedge clk);
    @(negedge clk);
    axis.num_tvalid = 1'b0;
    axis.den_tvalid = 1'b0;
  endtask

  // Wait for o_tvalid counting cycles from the accept cycle.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!axis.o_tvalid && lat < 100) begin
      @(negedge clk); lat++;
    end
    chk("o_tvalid_timeout", 64'(axis.o_tvalid), 64'd1);
  endtask

  task automatic get_result(input string tag, input logic [15:0] exp_q, input logic exp_last);
    int lat;
    wait_valid(lat);
    chk({tag, "_latency"}, 64'(lat), 64'd17);
    chk({tag, "_data"}, 64'(axis.o_tdata), 64'(exp_q));
    chk({tag, "_last"}, 64'(axis.o_tlast), 64'(exp_last));
    axis.o_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axis.o_tready = 1'b0;
    chk({tag, "_valid_drop"}, 64'(axis.o_tvalid), 64'd0);
  endtask

  task automatic expect_silence(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      seen = seen | axis.o_tvalid;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] n, d, r;
    logic [63:0] prod;
    logic [15:0] held_data;

    reset = 1'b1;
    clear = 1'b0;
    axis.num_tdata  = 32'd5;
    axis.den_tdata  = 32'd9;
    axis.num_tlast  = 1'b0;
    axis.den_tlast  = 1'b1;
    axis.num_tvalid = 1'b1;
    axis.den_tvalid = 1'b1;
    axis.o_tready   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_o_tvalid", 64'(axis.o_tvalid), 64'd0);
    chk("reset_o_tdata", 64'(axis.o_tdata), 64'd0);
    chk("reset_o_tlast", 64'(axis.o_tlast), 64'd0);
    chk("reset_tready", 64'({axis.num_tready, axis.den_tready}), 64'd0);
    axis.num_tvalid = 1'b0;
    axis.den_tvalid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Basic quotients
    send_pair(32'd1, 32'd2, 1'b1);        get_result("n1_d2", 16'h4000, 1'b1);
    send_pair(32'd1000, 32'd1000, 1'b0);  get_result("n1000_d1000", 16'h8000, 1'b0);
    send_pair(32'd1, 32'd3, 1'b1);        get_result("n1_d3", 16'h2AAA, 1'b1);

    // Saturation and zero cases
    send_pair(32'd3, 32'd1, 1'b0);        get_result("ovf_n3_d1", 16'hFFFF, 1'b0);
    send_pair(32'd5, 32'd0, 1'b1);        get_result("div_zero", 16'hFFFF, 1'b1);
    send_pair(32'd0, 32'd7, 1'b0);        get_result("zero_num", 16'h0000, 1'b0);

    // Staggered valids: no lone acceptance
    axis.num_tdata  = 32'd1;
    axis.den_tdata  = 32'd2;
    axis.den_tlast  = 1'b0;
    axis.num_tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lone_num_tready", 64'({axis.num_tready, axis.den_tready}), 64'd0);
      @(negedge clk);
    end
    send_pair(32'd1, 32'd2, 1'b0);
    get_result("staggered", 16'h4000, 1'b0);
    expect_silence("staggered_single_result", 20);

    // Backpressure in DONE with the next pair already waiting
    send_pair(32'd1, 32'd3, 1'b1);
    wait_valid(lat);
    chk("bp_data", 64'(axis.o_tdata), 64'h2AAA);
    held_data = axis.o_tdata;
    axis.num_tdata  = 32'd0;
    axis.den_tdata  = 32'd7;
    axis.den_tlast  = 1'b0;
    axis.num_tvalid = 1'b1;
    axis.den_tvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold", 64'({axis.o_tvalid, axis.o_tlast, axis.o_tdata, axis.num_tready, axis.den_tready}),
          64'({1'b1, 1'b1, held_data, 1'b0, 1'b0}));
    end
    axis.o_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    axis.o_tready = 1'b0;
    chk("bp_next_accept", 64'({axis.o_tvalid, axis.num_tready, axis.den_tready}), 64'b011);
    send_pair(32'd0, 32'd7, 1'b0);
    get_result("bp_next", 16'h0000, 1'b0);

    // Back-to-back random pairs against the reference model
    axis.o_tready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      r = $urandom;
      if (i % 16 == 5) d = 32'd0;
      prod = (64'(r) * 64'(d)) >> 31;
      n = (i % 8 == 3) ? $urandom : prod[31:0];
      axis.num_tdata  = n;
      axis.den_tdata  = d;
      axis.den_tlast  = (i == 63);
      axis.num_tvalid = 1'b1;
      axis.den_tvalid = 1'b1;
      #1;
      lat = 0;
      while (!axis.num_tready && lat < 50) begin
        @(negedge clk); #1; lat++;
      end
      chk("b2b_accept", 64'(axis.num_tready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      wait_valid(lat);
      chk("b2b_latency", 64'(lat), 64'd17);
      chk("b2b_data", 64'(axis.o_tdata), 64'(ref_q(n, d)));
      chk("b2b_last", 64'(axis.o_tlast), 64'(i == 63));
    end
    axis.num_tvalid = 1'b0;
    axis.den_tvalid = 1'b0;
    @(negedge clk);
    axis.o_tready = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of CALC
    send_pair(32'd1, 32'd3, 1'b1);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    axis.num_tvalid = 1'b1;
    axis.den_tvalid = 1'b1;
    #1;
    chk("rst_calc_outputs", 64'({axis.o_tvalid, axis.num_tready, axis.den_tready}), 64'd0);
    @(negedge clk);
    axis.num_tvalid = 1'b0;
    axis.den_tvalid = 1'b0;
    reset = 1'b0;
    expect_silence("rst_calc_no_output", 25);
    send_pair(32'd1000, 32'd1000, 1'b1);
    get_result("after_reset", 16'h8000, 1'b1);

    // Synchronous clear in the middle of CALC
    send_pair(32'd1, 32'd3, 1'b1);
    repeat (7) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    expect_silence("clr_calc_no_output", 25);
    send_pair(32'd1000, 32'd1000, 1'b0);
    get_result("after_clear", 16'h8000, 1'b0);

    // Clear in DONE drops outputs on the edge, reset drops them at once
    send_pair(32'd1, 32'd2, 1'b1);
    wait_valid(lat);
    clear = 1'b1;
    #1;
    chk("clr_done_before_edge", 64'(axis.o_tvalid), 64'd1);
    @(posedge clk);
    #1;
    chk("clr_done_after_edge", 64'({axis.o_tvalid, axis.o_tlast, axis.o_tdata}), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    send_pair(32'd1, 32'd2, 1'b1);
    wait_valid(lat);
    reset = 1'b1;
    #1;
    chk("rst_done_async", 64'({axis.o_tvalid, axis.o_tlast, axis.o_tdata}), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    expect_silence("rst_done_no_output", 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
